// File: rtl/pcie_tx_serializer_pkg.sv
// Shared definitions for the PCIE transmit serializer: idle symbol, width codes
// and the width-to-byte-count helper.
package pcie_tx_pkg;

  localparam logic [7:0] IDLE_SYM_K285 = 8'hBC;

  typedef enum logic [1:0] {
    W8   = 2'b00,
    W16  = 2'b01,
    W32  = 2'b10,
    WRSV = 2'b11
  } width_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_e;

  // Zero marks the reserved encoding so callers can reject it directly.
  function automatic logic [2:0] width_bytes(input logic [1:0] ws);
    case (width_e'(ws))
      W8:      width_bytes = 3'd1;
      W16:     width_bytes = 3'd2;
      W32:     width_bytes = 3'd4;
      default: width_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/pcie_tx_serializer_if.sv
// Word-in / serial-out bundle of the PCIE transmit serializer.
interface pcie_tx_serializer_if #(
  parameter int MAX_BYTES = 4
);
  logic                   enb;
  logic                   in_valid;
  logic                   in_ready;
  logic [8*MAX_BYTES-1:0] dataIn;
  logic [MAX_BYTES-1:0]   kIn;
  logic [1:0]             dataS;
  logic                   serialOut;
  logic                   kOut;
  logic                   symStart;
  logic                   idleOut;
  logic                   cfgErr;

  modport master (
    output enb, in_valid, dataIn, kIn, dataS,
    input  in_ready, serialOut, kOut, symStart, idleOut, cfgErr
  );

  modport slave (
    input  enb, in_valid, dataIn, kIn, dataS,
    output in_ready, serialOut, kOut, symStart, idleOut, cfgErr
  );

endinterface

// File: rtl/pcie_tx_serializer_tx_symbol_shifter.sv
// 8-bit symbol load/shift register: bit_out shows the current bit, k_out the
// K tag of the symbol being shifted.
module tx_symbol_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       load_k,
  output logic       bit_out,
  output logic       k_out
);

  logic [6:0] rest_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_out <= 1'b0;
      k_out   <= 1'b0;
    end else if (enb) begin
      if (load) begin
        bit_out <= load_data[0];
        k_out   <= load_k;
      end else begin
        bit_out <= rest_q[0];
      end
    end
  end

  // Remaining bits of the symbol; left unreset since a load always precedes use.
  always_ff @(posedge clk) begin
    if (enb) begin
      if (load) rest_q <= load_data[7:1];
      else      rest_q <= {1'b0, rest_q[6:1]};
    end
  end

endmodule

// File: rtl/pcie_tx_serializer.sv
// PCIE transmit serializer: takes 1/2/4-byte words with K flags and shifts them
// out LSB first, filling every gap with K28.5 idle symbols.
module pcie_tx_serializer
  import pcie_tx_pkg::*;
#(
  parameter int         MAX_BYTES = 4,
  parameter logic [7:0] IDLE_SYM  = IDLE_SYM_K285
) (
  input logic                 clk,
  input logic                 rst,
  pcie_tx_serializer_if.slave bus
);

  localparam int WORD_W = 8 * MAX_BYTES;

  state_e               state;
  logic [2:0]           bit_cnt;
  logic [1:0]           byte_cnt;
  logic [1:0]           n_last;
  logic [WORD_W-1:0]    word_q;
  logic [MAX_BYTES-1:0] k_q;

  logic [2:0] req_bytes;
  logic       legal;
  logic       boundary;
  logic       take;
  logic       sh_load;
  logic [7:0] sh_data;
  logic       sh_k;

  always_comb begin
    req_bytes = width_bytes(bus.dataS);
    legal     = (req_bytes != 3'd0) && (int'(req_bytes) <= MAX_BYTES);
    boundary  = (bit_cnt == 3'd7) && (byte_cnt == n_last);
    take      = boundary && bus.in_valid && legal;
  end

  assign bus.in_ready = bus.enb & ~rst & boundary & ~(bus.in_valid & ~legal);

  // Pick what the shifter loads: new word byte 0, an idle fill, or the next byte.
  always_comb begin
    sh_load = 1'b0;
    sh_data = IDLE_SYM;
    sh_k    = 1'b1;
    if (boundary) begin
      sh_load = 1'b1;
      if (take) begin
        sh_data = bus.dataIn[7:0];
        sh_k    = bus.kIn[0];
      end
    end else if (bit_cnt == 3'd7 && state == ST_DATA) begin
      sh_load = 1'b1;
      sh_data = word_q[7:0];
      sh_k    = k_q[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      bit_cnt      <= 3'd7;
      byte_cnt     <= 2'd0;
      n_last       <= 2'd0;
      bus.symStart <= 1'b0;
      bus.idleOut  <= 1'b0;
      bus.cfgErr   <= 1'b0;
    end else if (bus.enb) begin
      if (boundary) begin
        bit_cnt      <= 3'd0;
        byte_cnt     <= 2'd0;
        bus.symStart <= 1'b1;
        if (take) begin
          state       <= ST_DATA;
          n_last      <= 2'(req_bytes - 3'd1);
          bus.idleOut <= 1'b0;
          bus.cfgErr  <= 1'b0;
        end else begin
          state       <= ST_IDLE;
          n_last      <= 2'd0;
          bus.idleOut <= 1'b1;
          bus.cfgErr  <= bus.in_valid;
        end
      end else if (bit_cnt == 3'd7) begin
        bit_cnt      <= 3'd0;
        byte_cnt     <= byte_cnt + 2'd1;
        bus.symStart <= 1'b1;
        bus.cfgErr   <= 1'b0;
      end else begin
        bit_cnt      <= bit_cnt + 3'd1;
        bus.symStart <= 1'b0;
        bus.cfgErr   <= 1'b0;
      end
    end
  end

  // Word register holds the bytes still to send; byte 0 goes straight to the shifter.
  always_ff @(posedge clk) begin
    if (bus.enb) begin
      if (take) begin
        word_q <= bus.dataIn >> 8;
        k_q    <= bus.kIn >> 1;
      end else if (sh_load && !boundary) begin
        word_q <= word_q >> 8;
        k_q    <= k_q >> 1;
      end
    end
  end

  tx_symbol_shifter u_shifter (
    .clk       (clk),
    .rst       (rst),
    .enb       (bus.enb),
    .load      (sh_load),
    .load_data (sh_data),
    .load_k    (sh_k),
    .bit_out   (bus.serialOut),
    .k_out     (bus.kOut)
  );

endmodule

// File: tb/tb_pcie_tx_serializer.sv
// Directed bench for pcie_tx_serializer: idle fill, word widths, K flags,
// enable freeze, illegal widths and mid-word reset.
module tb_pcie_tx_serializer;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  pcie_tx_serializer_if #(.MAX_BYTES(4)) bus ();
  pcie_tx_serializer_if #(.MAX_BYTES(1)) nbus ();

  pcie_tx_serializer #(.MAX_BYTES(4), .IDLE_SYM(8'hBC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pcie_tx_serializer #(.MAX_BYTES(1), .IDLE_SYM(8'hBC)) dut_narrow (
    .clk (clk),
    .rst (rst),
    .bus (nbus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // {serialOut, kOut, symStart, idleOut, cfgErr}
  function automatic logic [4:0] outs();
    return {bus.serialOut, bus.kOut, bus.symStart, bus.idleOut, bus.cfgErr};
  endfunction

  function automatic logic [4:0] nouts();
    return {nbus.serialOut, nbus.kOut, nbus.symStart, nbus.idleOut, nbus.cfgErr};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.enb = 1'b1;
    nbus.in_valid = 1'b0;
    nbus.enb = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    rst = 1'b1;
    bus.enb = 1'b1;
    bus.in_valid = 1'b1;
    bus.dataS = 2'b00;
    bus.dataIn = 32'h0000_0011;
    tick();
    tick();
    obs = {outs(), bus.in_ready};
    checks++;
    if (obs !== 6'b0) begin
      errors++;
      $display("FAIL reset_state got %b exp %b", obs, 6'b0);
    end
    bus.in_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_idle();
    logic [7:0] idle_b;
    logic [4:0] exp;
    idle_b = 8'hBC;
    do_reset();
    for (int c = 0; c < 32; c++) begin
      tick();
      exp = {idle_b[c % 8], 1'b1, (c % 8) == 0, 1'b1, 1'b0};
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL idle_c%0d got %b exp %b", c, outs(), exp);
      end
    end
  endtask

  task automatic test_single_byte();
    logic [7:0] d;
    logic [4:0] exp;
    d = 8'hA5;
    do_reset();
    bus.in_valid = 1'b1;
    bus.dataS = 2'b00;
    bus.dataIn = 32'h0000_00A5;
    bus.kIn = 4'b0000;
    settle();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready got %b exp 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp = {d[i], 1'b0, i == 0, 1'b0, 1'b0};
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL single_bit%0d got %b exp %b", i, outs(), exp);
      end
      tick();
    end
    checks++;
    if (outs() !== 5'b01110) begin
      errors++;
      $display("FAIL single_idle_after got %b exp 01110", outs());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [6];
    logic [7:0] cur;
    logic [4:0] exp;
    logic       exp_rdy;
    b = '{8'hCD, 8'hAB, 8'h6F, 8'h45, 8'h23, 8'h01};
    do_reset();
    bus.in_valid = 1'b1;
    bus.dataS = 2'b01;
    bus.dataIn = 32'h0000_ABCD;
    bus.kIn = 4'b0000;
    settle();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_first got %b exp 1", bus.in_ready);
    end
    tick();
    bus.dataS = 2'b10;
    bus.dataIn = 32'h0123_456F;
    for (int i = 0; i < 48; i++) begin
      cur = b[i / 8];
      exp = {cur[i % 8], 1'b0, (i % 8) == 0, 1'b0, 1'b0};
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL b2b_bit%0d got %b exp %b", i, outs(), exp);
      end
      settle();
      exp_rdy = (i == 15) || (i == 47);
      checks++;
      if (bus.in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL b2b_ready%0d got %b exp %b", i, bus.in_ready, exp_rdy);
      end
      tick();
      if (i == 15) bus.in_valid = 1'b0;
    end
    checks++;
    if (outs() !== 5'b01110) begin
      errors++;
      $display("FAIL b2b_idle_after got %b exp 01110", outs());
    end
  endtask

  task automatic test_k_flags();
    logic [7:0] cur;
    logic [4:0] exp;
    do_reset();
    bus.in_valid = 1'b1;
    bus.dataS = 2'b10;
    bus.dataIn = 32'h0000_00BC;
    bus.kIn = 4'b0001;
    settle();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL kflag_ready got %b exp 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    bus.kIn = 4'b0000;
    for (int i = 0; i < 32; i++) begin
      cur = (i < 8) ? 8'hBC : 8'h00;
      exp = {cur[i % 8], i < 8, (i % 8) == 0, 1'b0, 1'b0};
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL kflag_bit%0d got %b exp %b", i, outs(), exp);
      end
      tick();
    end
  endtask

  task automatic test_enable_freeze();
    logic [7:0] d;
    logic [4:0] exp;
    d = 8'hA5;
    do_reset();
    bus.in_valid = 1'b1;
    bus.dataS = 2'b00;
    bus.dataIn = 32'h0000_00A5;
    bus.kIn = 4'b0000;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    bus.enb = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      exp = {d[2], 1'b0, 1'b0, 1'b0, 1'b0};
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL freeze_c%0d got %b exp %b", c, outs(), exp);
      end
    end
    bus.enb = 1'b1;
    for (int i = 3; i < 8; i++) begin
      tick();
      exp = {d[i], 1'b0, 1'b0, 1'b0, 1'b0};
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL resume_bit%0d got %b exp %b", i, outs(), exp);
      end
    end
    bus.in_valid = 1'b1;
    bus.dataIn = 32'h0000_003D;
    bus.enb = 1'b0;
    settle();
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL freeze_ready got %b exp 0", bus.in_ready);
    end
    tick();
    exp = {d[7], 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL freeze_boundary got %b exp %b", outs(), exp);
    end
    bus.enb = 1'b1;
    settle();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL unfreeze_ready got %b exp 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (outs() !== 5'b10100) begin
      errors++;
      $display("FAIL unfreeze_load got %b exp 10100", outs());
    end
  endtask

  task automatic test_bad_width_and_reset();
    do_reset();
    bus.in_valid = 1'b1;
    bus.dataS = 2'b11;
    bus.dataIn = 32'h0000_ABCD;
    settle();
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL badw_ready got %b exp 0", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (outs() !== 5'b01111) begin
      errors++;
      $display("FAIL badw_cfgerr got %b exp 01111", outs());
    end
    tick();
    checks++;
    if (outs() !== 5'b01010) begin
      errors++;
      $display("FAIL badw_cfgerr_drop got %b exp 01010", outs());
    end
    for (int c = 0; c < 6; c++) tick();
    bus.in_valid = 1'b1;
    bus.dataS = 2'b01;
    settle();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstw_ready got %b exp 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    checks++;
    if (outs() !== 5'b10000) begin
      errors++;
      $display("FAIL rstw_bit9 got %b exp 10000", outs());
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({outs(), bus.in_ready} !== 6'b0) begin
      errors++;
      $display("FAIL midword_reset got %b exp 000000", {outs(), bus.in_ready});
    end
    rst = 1'b0;
    tick();
    checks++;
    if (outs() !== 5'b01110) begin
      errors++;
      $display("FAIL post_reset_idle got %b exp 01110", outs());
    end
  endtask

  task automatic test_narrow_width();
    do_reset();
    nbus.in_valid = 1'b1;
    nbus.dataS = 2'b01;
    nbus.dataIn = 8'h12;
    nbus.kIn = 1'b0;
    settle();
    checks++;
    if (nbus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL narrow_ready_wide got %b exp 0", nbus.in_ready);
    end
    tick();
    checks++;
    if (nouts() !== 5'b01111) begin
      errors++;
      $display("FAIL narrow_cfgerr got %b exp 01111", nouts());
    end
    for (int c = 0; c < 7; c++) tick();
    nbus.dataS = 2'b00;
    settle();
    checks++;
    if (nbus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL narrow_ready_byte got %b exp 1", nbus.in_ready);
    end
    tick();
    nbus.in_valid = 1'b0;
    checks++;
    if (nouts() !== 5'b00100) begin
      errors++;
      $display("FAIL narrow_load got %b exp 00100", nouts());
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.enb = 1'b0;
    bus.in_valid = 1'b0;
    bus.dataIn = '0;
    bus.kIn = '0;
    bus.dataS = 2'b00;
    nbus.enb = 1'b1;
    nbus.in_valid = 1'b0;
    nbus.dataIn = '0;
    nbus.kIn = '0;
    nbus.dataS = 2'b00;
    test_reset();
    test_idle();
    test_single_byte();
    test_back_to_back();
    test_k_flags();
    test_enable_freeze();
    test_bad_width_and_reset();
    test_narrow_width();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
